hazard_stall_control: RTL and testbench
=======================================

Name: hazard_stall_control

Overview:
- Stall/flush side of the 5-stage pipeline's hazard handling; the forwarding unit resolves hazards by bypass, this block resolves the rest.
- Detects load-use and branch-operand hazards in the D stage, freezes the pipeline on data-memory wait, and flushes IF/D on taken branches.
- Drives the PC, IF/D and D/EX write-enables and bubble controls.
- Contains a memory-wait FSM with a watchdog.

Parameters:
REG_ADDR, 5, register address width
WDOG_CYCLES, 64, dmem wait cycles before wdog_err is raised (min 2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
if_id_src1  input  REG_ADDR  D-stage source 1
if_id_src2  input  REG_ADDR  D-stage source 2
if_id_uses_src2  input  1  D-stage instruction reads src2
if_id_is_branch  input  1  D-stage instruction is a branch (compared in D)
id_ex_regwrite  input  1  EX-stage instruction writes RF
id_ex_memread  input  1  EX-stage instruction is a load
id_ex_dst_reg  input  REG_ADDR  EX-stage destination
ex_mem_memread  input  1  MEM-stage instruction is a load
ex_mem_dst_reg  input  REG_ADDR  MEM-stage destination
ex_mem_memaccess  input  1  MEM-stage load or store present
dmem_ready  input  1  data memory completes access this cycle
branch_taken  input  1  D-stage branch resolved taken
pc_write  output  1  PC update enable
if_id_write  output  1  IF/D register enable
if_id_flush  output  1  IF/D cleared to NOP
id_ex_bubble  output  1  D/EX loaded with NOP
freeze  output  1  EX/MEM and MEM/WB hold
wdog_err  output  1  sticky: dmem wait exceeded WDOG_CYCLES

Behaviour:
- Reset values:
  - pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, freeze=0, wdog_err=0.
  - State RUN, wait counter 0.
- Register 0 never causes a hazard. A src2 match counts only when if_id_uses_src2=1.
- Hazard terms, evaluated combinationally every cycle:
  - LU: id_ex_memread and id_ex_dst_reg matches src1/src2.
  - BR1: if_id_is_branch, id_ex_regwrite, not id_ex_memread, and id_ex_dst_reg matches.
  - BR2: if_id_is_branch and id_ex_memread and id_ex_dst_reg matches.
  - BR3: if_id_is_branch and ex_mem_memread and ex_mem_dst_reg matches.
- Data stall (dstall = LU|BR1|BR2|BR3):
  - Drives pc_write=0, if_id_write=0, id_ex_bubble=1.
  - The pipeline advances, so the hazard clears by itself: LU/BR1/BR3 stall 1 cycle, BR2 stalls 2 cycles (becomes BR3 after the first).
- States:
  - RUN: if ex_mem_memaccess and !dmem_ready, freeze this cycle and go to DWAIT next.
  - DWAIT: freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0 (D/EX also held via freeze). The wait counter increments each cycle. On dmem_ready=1, that cycle is the last frozen cycle; go to RUN next with the counter cleared.
- Priority, highest first: freeze (RUN-with-miss or DWAIT) > dstall > branch_taken flush.
  - Under freeze, dstall and flush are suppressed (outputs as in DWAIT).
  - Under dstall, if_id_flush=0 even when branch_taken=1; the branch re-resolves when the stall ends.
- Taken branch: when branch_taken=1 and no freeze or dstall, if_id_flush=1 for exactly 1 cycle with pc_write=1.
- Watchdog:
  - When the counter reaches WDOG_CYCLES-1 while in DWAIT, wdog_err is set.
  - wdog_err is sticky until reset. The FSM keeps waiting; no abort.
  - The counter saturates at WDOG_CYCLES-1.
- Reset mid-DWAIT: next cycle in RUN, counter 0, all outputs at reset values, wdog_err cleared.
- Glitch-free requirement: all outputs are combinational from registered state plus inputs. No combinational path from dmem_ready to pc_write when in RUN with ex_mem_memaccess=0.

Optional Feature:
HAZARD_PERF_EN.
- Defined: adds 32-bit output counters perf_dstall_cycles (cycles with dstall and no freeze), perf_freeze_cycles (cycles with freeze=1) and perf_flushes (cycles with if_id_flush=1).
  - All three are wrap-around, cleared by reset, and updated on the clock edge ending the counted cycle.
- Undefined: these ports and registers do not exist. The remaining behaviour is identical.

Test Plan:
- Load r3 in EX, D instruction reads r3 as src1 → 1 cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, then all back to 1/1/0.
- Branch in D reading r5, load writing r5 in EX → 2 stall cycles (BR2 then BR3), then branch_taken=1 gives a 1-cycle if_id_flush.
- Load r0 in EX, D reads r0 → no stall. D reads r4 in src2 with if_id_uses_src2=0 and EX writes r4 → no stall.
- ex_mem_memaccess=1, dmem_ready low for 3 cycles then high → freeze=1 for 4 cycles (3 low plus the ready cycle), then freeze=0 with no extra bubble. A simultaneous load-use hazard is suppressed during the freeze and produces its 1-cycle stall after.
- WDOG_CYCLES=8, dmem_ready held low 20 cycles → wdog_err rises on the 8th DWAIT cycle and stays 1 after ready returns, until reset.
- Reset asserted during DWAIT → next cycle freeze=0, pc_write=1, wdog_err=0. With HAZARD_PERF_EN, all perf counters read 0.

Source files
------------

// File: rtl/hazard_stall_control.sv
// Stall/flush control for the 5-stage pipeline: load-use and branch-operand stalls,
// dmem-wait freeze FSM with sticky watchdog. Define HAZARD_PERF_EN for perf counters.
module hazard_stall_control #(
  parameter int unsigned REG_ADDR    = 5,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_ADDR-1:0] if_id_src1,
  input  logic [REG_ADDR-1:0] if_id_src2,
  input  logic                if_id_uses_src2,
  input  logic                if_id_is_branch,
  input  logic                id_ex_regwrite,
  input  logic                id_ex_memread,
  input  logic [REG_ADDR-1:0] id_ex_dst_reg,
  input  logic                ex_mem_memread,
  input  logic [REG_ADDR-1:0] ex_mem_dst_reg,
  input  logic                ex_mem_memaccess,
  input  logic                dmem_ready,
  input  logic                branch_taken,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                if_id_flush,
  output logic                id_ex_bubble,
  output logic                freeze,
  output logic                wdog_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_dstall_cycles,
  output logic [31:0]         perf_freeze_cycles,
  output logic [31:0]         perf_flushes
`endif
);

  localparam int unsigned CntW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WDOG_CYCLES - 1);

  typedef enum logic [0:0] {StRun, StDwait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wdog_q, wdog_d;

  logic id_ex_hit, ex_mem_hit;
  logic lu, br1, br2, br3, dstall, wdog_hit;

  // r0 never matches; src2 only matters when the D instruction actually reads it.
  always_comb begin
    id_ex_hit  = (id_ex_dst_reg != '0) &&
                 ((id_ex_dst_reg == if_id_src1) ||
                  (if_id_uses_src2 && (id_ex_dst_reg == if_id_src2)));
    ex_mem_hit = (ex_mem_dst_reg != '0) &&
                 ((ex_mem_dst_reg == if_id_src1) ||
                  (if_id_uses_src2 && (ex_mem_dst_reg == if_id_src2)));
    lu     = id_ex_memread & id_ex_hit;
    br1    = if_id_is_branch & id_ex_regwrite & ~id_ex_memread & id_ex_hit;
    br2    = if_id_is_branch & id_ex_memread & id_ex_hit;
    br3    = if_id_is_branch & ex_mem_memread & ex_mem_hit;
    dstall = lu | br1 | br2 | br3;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freeze  = 1'b0;
    unique case (state_q)
      StRun: begin
        // Gated by memaccess so dmem_ready has no effect when no access is pending.
        if (ex_mem_memaccess && !dmem_ready) begin
          freeze  = 1'b1;
          state_d = StDwait;
          cnt_d   = '0;
        end
      end
      StDwait: begin
        freeze = 1'b1;
        if (dmem_ready) begin
          state_d = StRun;
          cnt_d   = '0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StRun;
    endcase

    wdog_hit = (state_q == StDwait) && (cnt_q == CntMax);
    wdog_d   = wdog_q | wdog_hit;
    wdog_err = wdog_d;

    pc_write     = ~freeze & ~dstall;
    if_id_write  = ~freeze & ~dstall;
    id_ex_bubble = ~freeze & dstall;
    if_id_flush  = ~freeze & ~dstall & branch_taken;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
      wdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_dstall_q, perf_freeze_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_dstall_q <= '0;
      perf_freeze_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      if (dstall && !freeze) perf_dstall_q <= perf_dstall_q + 32'd1;
      if (freeze)            perf_freeze_q <= perf_freeze_q + 32'd1;
      if (if_id_flush)       perf_flush_q  <= perf_flush_q + 32'd1;
    end
  end

  assign perf_dstall_cycles = perf_dstall_q;
  assign perf_freeze_cycles = perf_freeze_q;
  assign perf_flushes       = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_control.sv
// Directed self-checking bench for hazard_stall_control (WDOG_CYCLES=8).
module tb_hazard_stall_control;

  localparam int unsigned RA = 5;

  // Output vector: {pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze, wdog_err}
  localparam logic [5:0] Normal   = 6'b110000;
  localparam logic [5:0] Stall    = 6'b000100;
  localparam logic [5:0] Flush    = 6'b111000;
  localparam logic [5:0] Frz      = 6'b000010;
  localparam logic [5:0] FrzWd    = 6'b000011;
  localparam logic [5:0] NormalWd = 6'b110001;

  logic          clk = 1'b0;
  logic          reset;
  logic [RA-1:0] if_id_src1, if_id_src2, id_ex_dst_reg, ex_mem_dst_reg;
  logic          if_id_uses_src2, if_id_is_branch, id_ex_regwrite, id_ex_memread;
  logic          ex_mem_memread, ex_mem_memaccess, dmem_ready, branch_taken;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze, wdog_err;
`ifdef HAZARD_PERF_EN
  logic [31:0]   perf_dstall_cycles, perf_freeze_cycles, perf_flushes;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_stall_control #(
    .REG_ADDR    (RA),
    .WDOG_CYCLES (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .if_id_src1       (if_id_src1),
    .if_id_src2       (if_id_src2),
    .if_id_uses_src2  (if_id_uses_src2),
    .if_id_is_branch  (if_id_is_branch),
    .id_ex_regwrite   (id_ex_regwrite),
    .id_ex_memread    (id_ex_memread),
    .id_ex_dst_reg    (id_ex_dst_reg),
    .ex_mem_memread   (ex_mem_memread),
    .ex_mem_dst_reg   (ex_mem_dst_reg),
    .ex_mem_memaccess (ex_mem_memaccess),
    .dmem_ready       (dmem_ready),
    .branch_taken     (branch_taken),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .id_ex_bubble     (id_ex_bubble),
    .freeze           (freeze),
    .wdog_err         (wdog_err)
`ifdef HAZARD_PERF_EN
    ,
    .perf_dstall_cycles (perf_dstall_cycles),
    .perf_freeze_cycles (perf_freeze_cycles),
    .perf_flushes       (perf_flushes)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    if_id_src1       = '0;
    if_id_src2       = '0;
    if_id_uses_src2  = 1'b0;
    if_id_is_branch  = 1'b0;
    id_ex_regwrite   = 1'b0;
    id_ex_memread    = 1'b0;
    id_ex_dst_reg    = '0;
    ex_mem_memread   = 1'b0;
    ex_mem_dst_reg   = '0;
    ex_mem_memaccess = 1'b0;
    dmem_ready       = 1'b0;
    branch_taken     = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    #1;
    obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze, wdog_err};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    clr();
    reset = 1'b1;
    tick();
    tick();
    chk("reset_held", Normal);
    reset = 1'b0;
    chk("reset_release", Normal);

    // Load-use on src1: one stall cycle, then the load has moved to MEM.
    tick(); clr();
    id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_dst_reg = 5'd3; if_id_src1 = 5'd3;
    chk("lu_stall", Stall);
    tick(); clr();
    ex_mem_memread = 1'b1; ex_mem_dst_reg = 5'd3; if_id_src1 = 5'd3;
    chk("lu_after", Normal);

    // Branch on r5 with a load to r5 in EX: BR2 then BR3, then taken flush.
    tick(); clr();
    if_id_is_branch = 1'b1; if_id_src1 = 5'd5;
    id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_dst_reg = 5'd5;
    chk("br2_stall", Stall);
    tick(); clr();
    if_id_is_branch = 1'b1; if_id_src1 = 5'd5; ex_mem_memread = 1'b1; ex_mem_dst_reg = 5'd5;
    chk("br3_stall", Stall);
    tick(); clr();
    if_id_is_branch = 1'b1; if_id_src1 = 5'd5; branch_taken = 1'b1;
    chk("br_flush", Flush);
    tick(); clr();
    chk("br_after_flush", Normal);

    // BR1: branch reading src2 produced by ALU op in EX.
    tick(); clr();
    if_id_is_branch = 1'b1; if_id_uses_src2 = 1'b1; if_id_src2 = 5'd7;
    id_ex_regwrite = 1'b1; id_ex_dst_reg = 5'd7;
    chk("br1_stall", Stall);
    // Same ALU producer for a non-branch consumer is forwarded, no stall.
    if_id_is_branch = 1'b0;
    chk("alu_no_stall", Normal);

    // r0 never hazards; unused src2 never hazards.
    tick(); clr();
    id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_dst_reg = 5'd0;
    chk("r0_no_stall", Normal);
    id_ex_dst_reg = 5'd4; if_id_src1 = 5'd1; if_id_src2 = 5'd4;
    chk("src2_unused", Normal);
    if_id_uses_src2 = 1'b1;
    chk("src2_used", Stall);
    // Stall suppresses the taken-branch flush.
    branch_taken = 1'b1;
    chk("stall_over_flush", Stall);

    // dmem_ready has no effect without a pending access.
    tick(); clr();
    dmem_ready = 1'b1;
    chk("no_access_rdy1", Normal);
    dmem_ready = 1'b0;
    chk("no_access_rdy0", Normal);

    // Three not-ready cycles plus the ready cycle frozen; pending load-use waits.
    tick(); clr();
    ex_mem_memaccess = 1'b1;
    id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_dst_reg = 5'd2; if_id_src1 = 5'd2;
    chk("frz_run_miss", Frz);
    tick();
    branch_taken = 1'b1;
    chk("frz_dwait1", Frz);
    tick();
    branch_taken = 1'b0;
    chk("frz_dwait2", Frz);
    tick();
    dmem_ready = 1'b1;
    chk("frz_ready", Frz);
    tick();
    ex_mem_memaccess = 1'b0; dmem_ready = 1'b0;
    chk("frz_then_lu", Stall);
    tick(); clr();
    chk("frz_done", Normal);

    // Watchdog: 20 not-ready cycles, error visible from the 8th DWAIT cycle.
    tick(); clr();
    ex_mem_memaccess = 1'b1;
    chk("wd_run_miss", Frz);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("wd_dwait%0d", i), Frz);
    end
    tick();
    chk("wd_dwait8", FrzWd);
    for (int i = 0; i < 11; i++) tick();
    chk("wd_dwait19", FrzWd);
    tick();
    dmem_ready = 1'b1;
    chk("wd_ready", FrzWd);
    tick(); clr();
    chk("wd_sticky", NormalWd);

    // Reset while waiting clears everything.
    tick();
    ex_mem_memaccess = 1'b1;
    chk("rst_run_miss", FrzWd);
    tick();
    chk("rst_dwait", FrzWd);
    reset = 1'b1;
    ex_mem_memaccess = 1'b0;
    tick();
    chk("rst_mid_dwait", Normal);
    reset = 1'b0;
    tick();
    chk("rst_after", Normal);
`ifdef HAZARD_PERF_EN
    tests++;
    assert ({perf_dstall_cycles, perf_freeze_cycles, perf_flushes} === 96'd0) else begin
      fails++;
      $error("FAIL perf_zero: observed %0d/%0d/%0d expected 0/0/0",
             perf_dstall_cycles, perf_freeze_cycles, perf_flushes);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
